// File: rtl/cdb_lane_arbiter_if.sv
// rtl/cdb_lane_arbiter_if.sv - EU request and CDB write-back lane bundle
interface cdb_lane_arbiter_if #(
    parameter int EU_N   = 8,
    parameter int LANES  = 2,
    parameter int DATA_W = 80
);
    logic [EU_N-1:0]         eu_valid_i;
    logic [EU_N-1:0]         eu_ready_o;
    logic [EU_N*DATA_W-1:0]  eu_data_i;
    logic [LANES-1:0]        cdb_valid_o;
    logic [LANES-1:0]        cdb_ready_i;
    logic [LANES*DATA_W-1:0] cdb_data_o;

    modport master (
        output eu_valid_i, eu_data_i, cdb_ready_i,
        input  eu_ready_o, cdb_valid_o, cdb_data_o
    );

    modport slave (
        input  eu_valid_i, eu_data_i, cdb_ready_i,
        output eu_ready_o, cdb_valid_o, cdb_data_o
    );
endinterface

// File: rtl/cdb_lane_arbiter.sv
// rtl/cdb_lane_arbiter.sv - grants up to LANES execution-unit results per cycle onto registered CDB lanes
module cdb_lane_arbiter #(
    parameter int EU_N   = 8,
    parameter int LANES  = 2,
    parameter int DATA_W = 80,
    parameter int RR_ARB = 1
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               flush_i,
    cdb_lane_arbiter_if.slave bus
);
    localparam int PW = (EU_N > 1) ? $clog2(EU_N) : 1;

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_nxt;
    logic [LANES-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [LANES];
    logic [DATA_W-1:0] payload [EU_N];
    logic [LANES-1:0]  free;
    logic [LANES-1:0]  lane_gnt;
    logic [PW-1:0]     lane_src [LANES];
    logic [EU_N-1:0]   gnt;
    logic              any_gnt;
    logic              arb_en;
    int                lane_rank [LANES];
    int                nfree;

    assign arb_en = rst_ni & ~flush_i;
    assign free   = ~valid_q | bus.cdb_ready_i;

    always_comb begin
        for (int k = 0; k < EU_N; k++) begin
            payload[k] = bus.eu_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Each free lane's rank among free lanes: the rank-th grant lands on it.
    always_comb begin
        nfree = 0;
        for (int l = 0; l < LANES; l++) begin
            lane_rank[l] = nfree;
            if (free[l]) begin
                nfree = nfree + 1;
            end
        end
        if (!arb_en) begin
            nfree = 0;
        end
    end

    always_comb begin
        int            idx;
        int            cnt;
        int            last;
        logic [PW-1:0] sel;
        gnt      = '0;
        lane_gnt = '0;
        idx      = 0;
        cnt      = 0;
        last     = int'(ptr_q);
        sel      = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_src[l] = '0;
        end
        for (int i = 0; i < EU_N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= EU_N) begin
                idx = idx - EU_N;
            end
            sel = PW'(idx);
            if (bus.eu_valid_i[sel] && (cnt < nfree)) begin
                gnt[sel] = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    if (free[l] && (lane_rank[l] == cnt)) begin
                        lane_gnt[l] = 1'b1;
                        lane_src[l] = sel;
                    end
                end
                last = idx;
                cnt  = cnt + 1;
            end
        end
        any_gnt = (cnt != 0);
        ptr_nxt = (last == EU_N - 1) ? '0 : PW'(last + 1);
    end

    assign bus.eu_ready_o  = gnt;
    assign bus.cdb_valid_o = valid_q;

    always_comb begin
        bus.cdb_data_o = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.cdb_data_o[l*DATA_W +: DATA_W] = data_q[l];
        end
    end

    // Flush drops lane valids but keeps data and pointer; grants are already blocked.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int l = 0; l < LANES; l++) begin
                data_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (flush_i) begin
                    valid_q[l] <= 1'b0;
                end else if (lane_gnt[l]) begin
                    valid_q[l] <= 1'b1;
                    data_q[l]  <= payload[lane_src[l]];
                end else if (bus.cdb_ready_i[l]) begin
                    valid_q[l] <= 1'b0;
                end
            end
            if ((RR_ARB != 0) && any_gnt) begin
                ptr_q <= ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// tb/tb_cdb_lane_arbiter.sv - scoreboard bench for round-robin and fixed-priority lane arbitration
module tb_cdb_lane_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush_a;
    logic flush_b;

    cdb_lane_arbiter_if #(.EU_N(4), .LANES(2), .DATA_W(8)) ifa ();
    cdb_lane_arbiter_if #(.EU_N(4), .LANES(2), .DATA_W(8)) ifb ();

    cdb_lane_arbiter #(.EU_N(4), .LANES(2), .DATA_W(8), .RR_ARB(1)) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush_a),
        .bus     (ifa)
    );

    cdb_lane_arbiter #(.EU_N(4), .LANES(2), .DATA_W(8), .RR_ARB(0)) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush_b),
        .bus     (ifb)
    );

    typedef struct {
        string      name;
        bit         inst;
        bit         chk_vld;
        bit         chk_dat;
        logic [3:0] rdy;
        logic [1:0] vld;
        logic [7:0] d0;
        logic [7:0] d1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input string what, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares against the DUT it names.
    initial begin
        exp_t       e;
        logic [3:0] a_rdy;
        logic [1:0] a_vld;
        logic [15:0] a_dat;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.inst) begin
                    a_rdy = ifb.eu_ready_o;
                    a_vld = ifb.cdb_valid_o;
                    a_dat = ifb.cdb_data_o;
                end else begin
                    a_rdy = ifa.eu_ready_o;
                    a_vld = ifa.cdb_valid_o;
                    a_dat = ifa.cdb_data_o;
                end
                cmp(e.name, "eu_ready", {4'b0, a_rdy}, {4'b0, e.rdy});
                if (e.chk_vld) cmp(e.name, "cdb_valid", {6'b0, a_vld}, {6'b0, e.vld});
                if (e.chk_dat) begin
                    cmp(e.name, "lane0", a_dat[7:0], e.d0);
                    cmp(e.name, "lane1", a_dat[15:8], e.d1);
                end
            end
        end
    end

    task automatic step(input bit inst, input logic rst, input logic flush,
                        input logic [3:0] v, input logic [1:0] rdy, input string name,
                        input logic [3:0] e_rdy, input logic [1:0] e_vld,
                        input bit chk_dat, input logic [7:0] e_d0, input logic [7:0] e_d1);
        exp_t e;
        rst_n = rst;
        if (inst) begin
            flush_b         = flush;
            ifb.eu_valid_i  = v;
            ifb.cdb_ready_i = rdy;
        end else begin
            flush_a         = flush;
            ifa.eu_valid_i  = v;
            ifa.cdb_ready_i = rdy;
        end
        e.name    = name;
        e.inst    = inst;
        e.chk_vld = 1'b1;
        e.chk_dat = chk_dat;
        e.rdy     = e_rdy;
        e.vld     = e_vld;
        e.d0      = e_d0;
        e.d1      = e_d1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        flush_a         = 1'b0;
        flush_b         = 1'b0;
        ifa.eu_valid_i  = 4'h0;
        ifa.cdb_ready_i = 2'b11;
        ifa.eu_data_i   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        ifb.eu_valid_i  = 4'h0;
        ifb.cdb_ready_i = 2'b11;
        ifb.eu_data_i   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(posedge clk);
        #1;

        step(0, 0, 0, 4'hF,    2'b11, "rst0",      4'b0000, 2'b00, 0, 8'h00, 8'h00);
        step(0, 0, 0, 4'hF,    2'b11, "rst1",      4'b0000, 2'b00, 1, 8'h00, 8'h00);
        step(0, 1, 0, 4'hF,    2'b11, "rr_c1",     4'b0011, 2'b00, 0, 8'h00, 8'h00);
        step(0, 1, 0, 4'hF,    2'b11, "rr_c2",     4'b1100, 2'b11, 1, 8'hA0, 8'hA1);
        step(0, 1, 0, 4'hF,    2'b11, "rr_c3",     4'b0011, 2'b11, 1, 8'hA2, 8'hA3);
        step(0, 1, 0, 4'b0100, 2'b01, "bp_one",    4'b0100, 2'b11, 1, 8'hA0, 8'hA1);
        step(0, 1, 0, 4'b0100, 2'b00, "bp_none",   4'b0000, 2'b11, 1, 8'hA2, 8'hA1);
        step(0, 1, 0, 4'b1001, 2'b11, "wrap",      4'b1001, 2'b11, 1, 8'hA2, 8'hA1);
        step(0, 1, 0, 4'b0000, 2'b00, "wrap_lane", 4'b0000, 2'b11, 1, 8'hA3, 8'hA0);
        step(0, 1, 0, 4'hF,    2'b11, "wrap_ptr",  4'b0110, 2'b11, 1, 8'hA3, 8'hA0);
        step(0, 1, 1, 4'hF,    2'b00, "flush",     4'b0000, 2'b11, 1, 8'hA1, 8'hA2);
        step(0, 1, 0, 4'hF,    2'b00, "post_fl",   4'b1001, 2'b00, 1, 8'hA1, 8'hA2);
        step(0, 1, 0, 4'h0,    2'b11, "drain",     4'b0000, 2'b11, 1, 8'hA3, 8'hA0);
        step(0, 1, 0, 4'h0,    2'b00, "idle",      4'b0000, 2'b00, 1, 8'hA3, 8'hA0);
        step(0, 0, 1, 4'hF,    2'b00, "rst_fl",    4'b0000, 2'b00, 1, 8'hA3, 8'hA0);
        step(0, 1, 0, 4'hF,    2'b00, "rst_ptr",   4'b0011, 2'b00, 1, 8'h00, 8'h00);

        step(1, 1, 0, 4'b1110, 2'b11, "fp_c1",     4'b0110, 2'b00, 1, 8'h00, 8'h00);
        step(1, 1, 0, 4'b1110, 2'b11, "fp_c2",     4'b0110, 2'b11, 1, 8'hA1, 8'hA2);
        step(1, 1, 0, 4'b1110, 2'b11, "fp_c3",     4'b0110, 2'b11, 1, 8'hA1, 8'hA2);
        step(1, 1, 0, 4'b0000, 2'b11, "fp_end",    4'b0000, 2'b11, 1, 8'hA1, 8'hA2);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_lane_arbiter.md
Name: cdb_lane_arbiter

Overview:
- Parametrised successor to the single-lane CDB arbitration that sits between the execution units (LSU, BU, ALU, MULT, DIV, FPU) and the ROB/reservation stations.
- Collects results from EU_N execution units and grants up to LANES of them per cycle onto LANES registered CDB write-back lanes.
- Supports round-robin or fixed-priority arbitration, per-lane back-pressure, and misprediction/exception flush.
- Instantiated by the execution stage; replaces the single cdb_ready/cdb_valid pair per EU.

Parameters:
- EU_N, 8, number of requesting execution units (≥2).
- LANES, 2, number of CDB write-back lanes (1..EU_N).
- DATA_W, 80, width of one CDB payload.
- RR_ARB, 1, 1 = round-robin, 0 = fixed priority (lowest EU index wins).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  drop all in-flight lane contents and block grants this cycle.
- eu_valid_i  in  EU_N  result valid from each EU.
- eu_ready_o  out  EU_N  grant/accept to each EU.
- eu_data_i  in  EU_N*DATA_W  EU payloads; EU k occupies bits [k*DATA_W +: DATA_W].
- cdb_valid_o  out  LANES  lane valid.
- cdb_ready_i  in  LANES  lane consumer ready.
- cdb_data_o  out  LANES*DATA_W  lane payloads; lane l occupies bits [l*DATA_W +: DATA_W].

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): all lane valid bits = 0, lane data = 0, RR pointer = 0.
  - While rst_ni=0, eu_ready_o = 0.
- Lane state: each lane is a one-entry register (valid + data). cdb_valid_o and cdb_data_o are driven directly from the registers.
- Lane free condition: free[l] = ~valid[l] | cdb_ready_i[l]. A lane being drained in the same cycle counts as free (no bubble).
- Arbitration (combinational within the cycle):
  - Requesters are scanned in priority order starting at ptr and wrapping modulo EU_N. With RR_ARB=0, ptr is constantly 0.
  - Free lanes are assigned in ascending lane index.
  - The i-th granted EU in priority order goes to the i-th free lane.
  - Number of grants = min(popcount(eu_valid_i), popcount(free)).
- eu_ready_o[k] = 1 only for granted EUs.
  - eu_ready_o may depend on eu_valid_i.
  - EUs must not make eu_valid_i depend on eu_ready_o.
  - Handshake on EU k = eu_valid_i[k] & eu_ready_o[k].
- Latency: 1 cycle. Data granted in cycle t appears on its lane's cdb_data_o with cdb_valid_o=1 in cycle t+1.
- Lane update at each edge:
  - If the lane is granted: valid=1, data=granted payload.
  - Else if cdb_ready_i[l] & valid[l]: valid=0.
  - Else: hold. Data must be stable while valid & ~ready.
- Pointer update (RR_ARB=1):
  - If ≥1 grant: ptr = (index of last granted EU in priority order + 1) mod EU_N.
  - If no grant: ptr is unchanged.
- Flush (flush_i=1):
  - eu_ready_o = 0 for that cycle.
  - All lane valid bits are cleared at the edge, regardless of cdb_ready_i.
  - Lane data is not cleared. ptr is unchanged.
- Simultaneous rst_ni=0 and flush_i=1: reset dominates.
- LANES ≥ EU_N: every valid EU is granted whenever enough lanes are free.
- No request and no free lane are both legal steady states; outputs hold.

Test Plan:
All scenarios use EU_N=4, LANES=2, DATA_W=8.
1. Reset: hold rst_ni=0 for 2 cycles with eu_valid_i=4'hF -> eu_ready_o=0 and cdb_valid_o=2'b00. After release with lanes empty and ptr=0 -> eu_ready_o=4'b0011.
2. Round-robin fill:
   - Inputs: eu_valid_i=4'hF, data EUk=8'hA0+k, cdb_ready_i=2'b11.
   - Cycle 1: grants 4'b0011 -> next cycle lane0=A0, lane1=A1, ptr=2.
   - Cycle 2: grants 4'b1100 -> lane0=A2, lane1=A3.
3. Back-pressure:
   - Setup: lanes hold A0/A1, cdb_ready_i=2'b01, eu_valid_i=4'b0100.
   - Required: only EU2 granted; next cycle lane0=A2, lane1 still A1 with valid=1.
   - With cdb_ready_i=2'b00 -> eu_ready_o=0.
4. Wrap-around: ptr=3, eu_valid_i=4'b1001, lanes free -> EU3 to lane0, EU0 to lane1, next ptr=1.
5. Flush:
   - Setup: lanes valid, eu_valid_i=4'hF, flush_i=1, cdb_ready_i=2'b00.
   - Required: eu_ready_o=0; next cycle cdb_valid_o=2'b00 and ptr unchanged.
6. Fixed priority (RR_ARB=0): eu_valid_i=4'b1110 held for 3 cycles with cdb_ready_i=2'b11 -> EU1 and EU2 granted every cycle, and EU3 is never granted.
